// File: rtl/sopc_bus_ic_if.sv
// sopc_bus_ic_if
// Bundles the CPU-side request/response signals and the broadcast slave-side
// signals of the SOPC data bus. Signal names keep the _i/_o suffixes as seen
// from the interconnect, so the RTL reads like a flat port list.
//   master : view of the CPU data port (drives the request, sees data/stall/err)
//   slave  : view of the peripheral slaves (see select/broadcast, drive data/ack)
//   ic     : view of the interconnect itself
interface sopc_bus_ic_if #(
   parameter int NSLV = 4,
   parameter int DW   = 32,
   parameter int AW   = 32
);
   logic                 m_ce_i;
   logic                 m_we_i;
   logic [AW-1:0]        m_addr_i;
   logic [DW/8-1:0]      m_sel_i;
   logic [DW-1:0]        m_data_i;
   logic [DW-1:0]        m_data_o;
   logic                 m_stall_o;
   logic                 m_err_o;
   logic [NSLV-1:0]      s_ce_o;
   logic                 s_we_o;
   logic [AW-1:0]        s_addr_o;
   logic [DW/8-1:0]      s_sel_o;
   logic [DW-1:0]        s_data_o;
   logic [NSLV*DW-1:0]   s_data_i;
   logic [NSLV-1:0]      s_ack_i;

   modport master (
      output m_ce_i, m_we_i, m_addr_i, m_sel_i, m_data_i,
      input  m_data_o, m_stall_o, m_err_o
   );

   modport slave (
      input  s_ce_o, s_we_o, s_addr_o, s_sel_o, s_data_o,
      output s_data_i, s_ack_i
   );

   modport ic (
      input  m_ce_i, m_we_i, m_addr_i, m_sel_i, m_data_i,
      output m_data_o, m_stall_o, m_err_o,
      output s_ce_o, s_we_o, s_addr_o, s_sel_o, s_data_o,
      input  s_data_i, s_ack_i
   );
endinterface

// File: rtl/sopc_bus_ic.sv
// sopc_bus_ic
// Address-decoded data-bus interconnect between the OpenMIPS CPU data port
// and NSLV slaves (RAM, timer, UART, GPIO ...). An access is latched in IDLE,
// the selected slave is held in BUSY until it acknowledges, and the result is
// presented for exactly one DONE cycle. The CPU is stalled from the request
// cycle until DONE. Unmapped addresses complete with a one-cycle error pulse.
//
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous reset, active-high
//   bus  - sopc_bus_ic_if.ic : m_* CPU request/response, s_* slave broadcast,
//          one-hot select s_ce_o, per-slave read data s_data_i and ack s_ack_i
//
// Optional feature: define BUS_TIMEOUT_EN to abort a BUSY access with an error
// after TIMEOUT wait cycles without acknowledge. Without it TIMEOUT is unused.
module sopc_bus_ic #(
   parameter int NSLV = 4,
   parameter int DW   = 32,
   parameter int AW   = 32,
   parameter logic [NSLV*AW-1:0] SLV_BASE = {32'h3000_0000, 32'h2000_0000,
                                             32'h1000_0000, 32'h0000_0000},
   parameter logic [NSLV*AW-1:0] SLV_MASK = {4{32'hF000_0000}},
   parameter int TIMEOUT = 255
) (
   input  logic      clk,
   input  logic      rst,
   sopc_bus_ic_if.ic bus
);

   localparam int IW = (NSLV > 1) ? $clog2(NSLV) : 1;

   typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

   state_t            state_q, state_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic              err_q, err_d;
   logic              we_q, we_d;
   logic [AW-1:0]     addr_q, addr_d;
   logic [DW/8-1:0]   sel_q, sel_d;
   logic [DW-1:0]     wdata_q, wdata_d;
   logic [DW-1:0]     rdata_q, rdata_d;

   logic [NSLV-1:0]   match;
   logic [DW-1:0]     slv_rdata [NSLV];
   logic              hit;
   logic [IW-1:0]     hit_idx;
   logic              ack_sel;

`ifdef BUS_TIMEOUT_EN
   localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
   logic [CW-1:0]     cnt_q, cnt_d;
`else
   localparam int unused_timeout = TIMEOUT;
`endif

   // Per-slave address decode and read-data slicing.
   generate
      for (genvar gi = 0; gi < NSLV; gi++) begin : g_slv
         assign match[gi]     = (bus.m_addr_i & SLV_MASK[gi*AW +: AW]) == SLV_BASE[gi*AW +: AW];
         assign slv_rdata[gi] = bus.s_data_i[gi*DW +: DW];
      end
   endgenerate

   // Priority encode: scanning downwards leaves the lowest matching index.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int k = NSLV - 1; k >= 0; k--) begin
         if (match[k]) begin
            hit     = 1'b1;
            hit_idx = IW'(k);
         end
      end
   end

   // Only the latched slave's acknowledge is honoured.
   assign ack_sel = bus.s_ack_i[idx_q];

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      err_d   = err_q;
      we_d    = we_q;
      addr_d  = addr_q;
      sel_d   = sel_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
`ifdef BUS_TIMEOUT_EN
      cnt_d   = cnt_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (bus.m_ce_i) begin
               if (hit) begin
                  we_d    = bus.m_we_i;
                  addr_d  = bus.m_addr_i;
                  sel_d   = bus.m_sel_i;
                  wdata_d = bus.m_data_i;
                  idx_d   = hit_idx;
                  state_d = ST_BUSY;
`ifdef BUS_TIMEOUT_EN
                  cnt_d   = '0;
`endif
               end else begin
                  // Unmapped: nothing reaches a slave, finish with an error.
                  err_d   = 1'b1;
                  rdata_d = '0;
                  state_d = ST_DONE;
               end
            end
         end
         ST_BUSY: begin
            if (ack_sel) begin
               rdata_d = we_q ? '0 : slv_rdata[idx_q];
               state_d = ST_DONE;
`ifdef BUS_TIMEOUT_EN
            end else if (cnt_q + CW'(1) == CW'(TIMEOUT)) begin
               err_d   = 1'b1;
               rdata_d = '0;
               state_d = ST_DONE;
            end else begin
               cnt_d   = cnt_q + CW'(1);
`endif
            end
         end
         ST_DONE: begin
            err_d   = 1'b0;
            state_d = ST_IDLE;
         end
         default: begin
            err_d   = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         err_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         sel_q   <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
`ifdef BUS_TIMEOUT_EN
         cnt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         err_q   <= err_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         sel_q   <= sel_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
`ifdef BUS_TIMEOUT_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

   // Stall is combinational so the CPU freezes in the very cycle it requests.
   assign bus.m_stall_o = ((state_q == ST_IDLE) && bus.m_ce_i) || (state_q == ST_BUSY);
   assign bus.m_err_o   = (state_q == ST_DONE) && err_q;
   assign bus.m_data_o  = rdata_q;
   assign bus.s_ce_o    = (state_q == ST_BUSY) ? (NSLV'(1) << idx_q) : '0;
   assign bus.s_we_o    = we_q;
   assign bus.s_addr_o  = addr_q;
   assign bus.s_sel_o   = sel_q;
   assign bus.s_data_o  = wdata_q;

endmodule

// File: tb/tb_sopc_bus_ic.sv
// tb_sopc_bus_ic
// Randomised and directed accesses against a transaction-level model of the
// bus: decode picks the lowest matching region, an access costs 3 + wait
// cycles (2 when unmapped), reads return the acknowledging slave's data and
// writes/errors return zero. Acks are generated by the bench acting as slaves.
`timescale 1ns/1ps
module tb_sopc_bus_ic;

   localparam int NSLV       = 4;
   localparam int TB_TIMEOUT = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;
   int   n_txn    = 0;

   logic [31:0] tb_base [NSLV] = '{32'h0000_0000, 32'h1000_0000, 32'h2000_0000, 32'h3000_0000};
   logic [31:0] tb_mask [NSLV] = '{32'hF000_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000};

   sopc_bus_ic_if #(.NSLV(NSLV), .DW(32), .AW(32)) bus ();

   sopc_bus_ic #(
      .NSLV(NSLV), .DW(32), .AW(32), .TIMEOUT(TB_TIMEOUT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic void find_slave(input logic [31:0] a, output bit hit, output int k);
      hit = 1'b0;
      k   = 0;
      for (int i = 0; i < NSLV; i++) begin
         if (!hit && ((a & tb_mask[i]) == tb_base[i])) begin
            hit = 1'b1;
            k   = i;
         end
      end
   endfunction

   // One complete access. The bench plays the slaves: slave k acks on its
   // (wait_n+1)-th select cycle, or never when never_ack is set.
   task automatic do_access(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                            input logic [31:0] wdata, input int wait_n, input bit never_ack,
                            input bit stray, input logic [31:0] rdata);
      bit          hit, done, exp_err;
      int          k, b, cyc, stall_cnt, done_cyc, exp_busy, exp_total;
      logic [31:0] exp_data;
      find_slave(addr, hit, k);
      exp_busy  = never_ack ? TB_TIMEOUT : wait_n + 1;
      exp_err   = !hit || never_ack;
      exp_data  = (hit && !we && !never_ack) ? rdata : 32'h0;
      exp_total = hit ? exp_busy + 2 : 2;

      bus.m_ce_i   = 1'b1;
      bus.m_we_i   = we;
      bus.m_addr_i = addr;
      bus.m_sel_i  = sel;
      bus.m_data_i = wdata;
      #1;
      check_eq("stall_c0", bus.m_stall_o, 1);
      check_eq("ce_c0", bus.s_ce_o, 0);

      cyc = 0; stall_cnt = 1; b = 0; done = 0; done_cyc = 0;
      while (!done && cyc < 60) begin
         @(negedge clk);
         cyc++;
         if (bus.m_stall_o) stall_cnt++;
         bus.s_data_i = {$urandom, $urandom, $urandom, $urandom};
         bus.s_ack_i  = '0;
         if (bus.s_ce_o != 0) begin
            b++;
            if (b == 1) begin
               check_eq("s_ce", bus.s_ce_o, 64'(1) << k);
               check_eq("s_addr", bus.s_addr_o, addr);
               check_eq("s_we", bus.s_we_o, we);
               check_eq("s_sel", bus.s_sel_o, sel);
               check_eq("s_data", bus.s_data_o, wdata);
            end
            if (!never_ack && b == wait_n + 1) begin
               bus.s_ack_i[k]          = 1'b1;
               bus.s_data_i[k*32 +: 32] = rdata;
            end else if (stray && b == 1) begin
               bus.s_ack_i[(k+1)%NSLV]              = 1'b1;
               bus.s_data_i[((k+1)%NSLV)*32 +: 32] = 32'hFFFF_FFFF;
            end
         end
         if (!bus.m_stall_o) begin
            done     = 1'b1;
            done_cyc = cyc;
            check_eq("m_data", bus.m_data_o, exp_data);
            check_eq("m_err", bus.m_err_o, exp_err);
         end
         bus.m_ce_i = 1'b0;
      end
      if (!done) begin
         check_eq("done_reached", 0, 1);
      end else begin
         check_eq("total_cycles", done_cyc + 1, exp_total);
         check_eq("stall_cycles", stall_cnt, exp_total - 1);
         check_eq("busy_cycles", b, hit ? exp_busy : 0);
      end
      @(negedge clk);
      bus.s_ack_i = '0;
      check_eq("err_after", bus.m_err_o, 0);
      check_eq("stall_after", bus.m_stall_o, 0);
      n_txn++;
      $display("TXN %0d we=%0d addr=%08h sel=%h wait=%0d hung=%0d -> data=%08h err=%0d cycles=%0d",
               n_txn, we, addr, sel, wait_n, never_ack, bus.m_data_o, exp_err, done_cyc + 1);
   endtask

   task automatic check_idle_zero(input string tag);
      check_eq({tag, "_stall"}, bus.m_stall_o, 0);
      check_eq({tag, "_ce"}, bus.s_ce_o, 0);
      check_eq({tag, "_err"}, bus.m_err_o, 0);
      check_eq({tag, "_mdata"}, bus.m_data_o, 0);
      check_eq({tag, "_we"}, bus.s_we_o, 0);
      check_eq({tag, "_addr"}, bus.s_addr_o, 0);
      check_eq({tag, "_sel"}, bus.s_sel_o, 0);
      check_eq({tag, "_wdata"}, bus.s_data_o, 0);
   endtask

   initial begin
      bus.m_ce_i   = 1'b0;
      bus.m_we_i   = 1'b0;
      bus.m_addr_i = '0;
      bus.m_sel_i  = '0;
      bus.m_data_i = '0;
      bus.s_data_i = '0;
      bus.s_ack_i  = '0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_idle_zero("reset");
      rst = 1'b0;
      @(negedge clk);

      // Directed cases.
      do_access(1'b0, 32'h1000_0004, 4'hF, 32'h0, 2, 1'b0, 1'b0, 32'hDEAD_BEEF);
      do_access(1'b1, 32'h0000_0010, 4'b0011, 32'h1234_5678, 0, 1'b0, 1'b0, 32'hAAAA_5555);
      do_access(1'b0, 32'h8000_0000, 4'hF, 32'h0, 0, 1'b0, 1'b0, 32'h0);
      do_access(1'b0, 32'h2000_0000, 4'hF, 32'h0, 2, 1'b0, 1'b1, 32'h5A5A_5A5A);
      // Ack on the cycle the wait count would reach the limit: completes normally.
      do_access(1'b0, 32'h3000_0008, 4'hF, 32'h0, TB_TIMEOUT - 1, 1'b0, 1'b0, 32'h0BAD_F00D);

`ifdef BUS_TIMEOUT_EN
      do_access(1'b0, 32'h3000_0000, 4'hF, 32'h0, 0, 1'b1, 1'b0, 32'h0);
`else
      begin
         int stall_hi;
         bus.m_ce_i   = 1'b1;
         bus.m_we_i   = 1'b0;
         bus.m_addr_i = 32'h3000_0000;
         stall_hi = 0;
         for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bus.m_ce_i = 1'b0;
            if (bus.m_stall_o) stall_hi++;
         end
         check_eq("hang_stall", stall_hi, 20);
         rst = 1'b1;
         @(negedge clk);
         rst = 1'b0;
         check_eq("hang_recover_stall", bus.m_stall_o, 0);
         $display("TXN hang read 3000_0000 stall held %0d cycles", stall_hi);
      end
`endif

      // Reset during the second BUSY cycle; the ack in that cycle must be lost.
      do_access(1'b0, 32'h1000_0020, 4'hF, 32'h0, 0, 1'b0, 1'b0, 32'h7777_1111);
      bus.m_ce_i   = 1'b1;
      bus.m_we_i   = 1'b0;
      bus.m_addr_i = 32'h1000_0004;
      bus.m_sel_i  = 4'hF;
      @(negedge clk);
      bus.m_ce_i = 1'b0;
      check_eq("rst_busy_ce", bus.s_ce_o, 4'b0010);
      @(negedge clk);
      rst = 1'b1;
      bus.s_ack_i = 4'b0010;
      bus.s_data_i[63:32] = 32'hCAFE_F00D;
      @(negedge clk);
      rst = 1'b0;
      bus.s_ack_i = '0;
      check_idle_zero("midrst");
      @(negedge clk);
      check_eq("midrst_err_next", bus.m_err_o, 0);
      $display("TXN reset mid-access on slave 1");
      do_access(1'b0, 32'h0000_0000, 4'hF, 32'h0, 1, 1'b0, 1'b0, 32'h1357_9BDF);

      // Randomised traffic.
      for (int t = 0; t < 150; t++) begin
         logic [31:0] a;
         int          nib, w;
         nib = $urandom_range(0, 5);
         if (nib > 3) nib = $urandom_range(4, 15);
         a = {nib[3:0], 28'($urandom)};
         w = $urandom_range(0, 3);
         do_access(1'($urandom), a, 4'($urandom), $urandom, w, 1'b0,
                   (w > 0) && ($urandom_range(0, 1) == 1), $urandom);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/sopc_bus_ic.md
# sopc_bus_ic

Parametrised data-bus interconnect for the OpenMIPS SOPC. It replaces the direct CPU-to-data_ram wiring with an address-decoded, multi-slave bus, so RAM, timer, UART and GPIO blocks can share the CPU data port. A registered request/acknowledge handshake lets slaves insert wait states, and a stall output holds the CPU pipeline until the access completes. Unmapped addresses and optionally hung slaves end the access with an error pulse.

## Interface
Parameters:
- NSLV, 4, number of slave channels (1..8)
- DW, 32, data width; byte selects are DW/8 bits
- AW, 32, address width
- SLV_BASE, {32'h3000_0000,32'h2000_0000,32'h1000_0000,32'h0000_0000}, NSLV×AW base addresses; slave k occupies bits [k*AW +: AW]
- SLV_MASK, {4{32'hF000_0000}}, NSLV×AW decode masks; slave k matches when (addr & mask_k) == base_k
- TIMEOUT, 255, wait-cycle limit; used only when BUS_TIMEOUT_EN is defined

Ports:
- clk  in  1  system clock; all state changes on its rising edge
- rst  in  1  synchronous reset, active-high
- m_ce_i  in  1  master access request
- m_we_i  in  1  1 = write, 0 = read
- m_addr_i  in  AW  byte address
- m_sel_i  in  DW/8  byte enables
- m_data_i  in  DW  write data
- m_data_o  out  DW  read data; valid in the DONE cycle only
- m_stall_o  out  1  hold master pipeline
- m_err_o  out  1  one-cycle error pulse in the DONE cycle
- s_ce_o  out  NSLV  one-hot slave select
- s_we_o  out  1  latched write enable, broadcast to all slaves
- s_addr_o  out  AW  latched address, broadcast
- s_sel_o  out  DW/8  latched byte enables, broadcast
- s_data_o  out  DW  latched write data, broadcast
- s_data_i  in  NSLV×DW  slave read data; slave k at [k*DW +: DW]
- s_ack_i  in  NSLV  slave acknowledge

## Operation
FSM states:
- IDLE
  - m_ce_i=1 with a matching slave: latch we, addr, sel and data; latch slave index k; go to BUSY.
  - m_ce_i=1 with no matching slave: set err flag; go to DONE. No s_ce_o is asserted and write data is dropped.
  - Overlapping regions: the lowest matching index wins.
- BUSY
  - s_ce_o[k]=1 and all other bits 0.
  - s_ack_i[k]=1: capture s_data_i[k] (reads) into the m_data_o register; go to DONE.
  - Acks from non-selected slaves are ignored.
- DONE
  - s_ce_o=0, m_stall_o=0.
  - m_err_o is driven from the err flag.
  - Go to IDLE unconditionally.
  - The err flag clears on entering IDLE.
- m_stall_o = (IDLE and m_ce_i) or BUSY. This term is combinational, so the master stalls in the same cycle it raises a request.
- m_data_o is 0 for writes and for errors. It holds its value outside DONE, and masters must sample it only in DONE.
- Reset values: state IDLE; all of s_ce_o, s_we_o, s_addr_o, s_sel_o, s_data_o, m_data_o, m_err_o and the timeout counter are 0.
- Reset mid-access: the FSM goes to IDLE on the edge where rst=1. A slave ack in that cycle is discarded, and no DONE or err is produced.

## Timing
- Cycle 0: request in IDLE; stall=1.
- Cycle 1: BUSY; s_ce_o[k]=1; a zero-wait slave acks in this cycle.
- Cycle 2: DONE; m_data_o valid; stall=0.
- Minimum access is 3 cycles with stall high for 2. Each slave wait cycle adds 1 cycle.
- Unmapped access: cycle 0 IDLE, then cycle 1 DONE with err=1.
- A new request may appear in the cycle after DONE. A request held through DONE is treated as a new access in the following IDLE cycle.
- Back-to-back throughput: 1 access per 3 cycles at minimum.

## Configuration
- BUS_TIMEOUT_EN defined:
  - An 8-bit-or-wider counter clears on entering BUSY and increments every BUSY cycle without an ack.
  - When it reaches TIMEOUT, the FSM goes to DONE with err=1, m_data_o=0 and s_ce_o dropped.
  - An ack arriving in the same cycle as the count reaching TIMEOUT wins: normal completion, err=0.
- BUS_TIMEOUT_EN undefined:
  - No counter; BUSY waits indefinitely for s_ack_i[k].
  - The TIMEOUT parameter is ignored.

## Test plan
- Read 0x1000_0004; slave 1 acks 2 cycles after s_ce_o[1] rises with 0xDEAD_BEEF. Required: s_ce_o=4'b0010, s_addr_o=0x1000_0004, stall high for 4 cycles, m_data_o=0xDEAD_BEEF in DONE, err=0.
- Write 0x0000_0010, data 0x1234_5678, sel 4'b0011; slave 0 acks with zero wait. Required: s_we_o=1, s_sel_o=4'b0011, s_data_o=0x1234_5678, 3-cycle access, m_data_o=0.
- Access 0x8000_0000 (unmapped). Required: s_ce_o stays 0, err=1 in cycle 1, stall high only in cycle 0.
- Read slave 2 while slave 3 pulses ack with 0xFFFF_FFFF; slave 2 then acks with 0x5A5A_5A5A. Required: stray ack ignored, m_data_o=0x5A5A_5A5A.
- With BUS_TIMEOUT_EN and TIMEOUT=4, read slave 3, which never acks. Required: DONE after 4 BUSY cycles, err=1, m_data_o=0. Without the macro the bench sees stall held high indefinitely.
- Assert rst in the second BUSY cycle of a slave-1 read. Required: next cycle IDLE, all outputs 0, no err pulse; a following read of 0x0000_0000 completes normally.
